// File: rtl/tick_logger.sv
// tick_logger: records each 1 kHz tick as a sequential SRAM write.
//
// Every PULSE increments COUNT. The incremented count is written to the
// next SRAM address through a REQ/ACK handshake. One tick can wait in a
// hold register while a write is outstanding. A tick that arrives while
// that register is already occupied is dropped, and OVERRUN is set.
//
// Parameters:
//   ADDR_W  - SRAM address width
//   DATA_W  - count and write-data width
// Ports:
//   CLK     in   system clock; all logic is on the rising edge
//   RST     in   synchronous, active-high reset
//   PULSE   in   one-cycle tick
//   ACK     in   SRAM write acknowledge, one cycle
//   REQ     out  write request; held high until ACK
//   ADDR    out  write address; advances after each acknowledged write
//   WDATA   out  write data
//   COUNT   out  running tick count
//   OVERRUN out  sticky; a tick was dropped
//   WRAPPED out  sticky; ADDR has rolled over from all-ones to zero
//   ERR     out  sticky; ACK timeout
//
// Build option: define TICK_LOGGER_TIMEOUT_EN to enable an ACK timeout.
// When it is enabled, a write that waits 255 cycles without ACK is
// abandoned and ERR is set. When it is not defined, ERR is tied to 0.

module tick_logger #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PULSE,
  input  logic              ACK,
  output logic              REQ,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] COUNT,
  output logic              OVERRUN,
  output logic              WRAPPED,
  output logic              ERR
);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              wrapped_q, wrapped_d;
  logic [DATA_W-1:0] tick_val;

`ifdef TICK_LOGGER_TIMEOUT_EN
  logic [7:0] timer_q, timer_d;
  logic       err_q, err_d;
  logic       timeout;
`endif

  assign tick_val = count_q + DATA_W'(1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    wrapped_d = wrapped_q;
`ifdef TICK_LOGGER_TIMEOUT_EN
    err_d   = err_q;
    timer_d = 8'd0;
    // timer_q counts completed cycles in WRITE, so 254 marks the 255th cycle.
    timeout = (state_q == StWrite) && !ACK && (timer_q == 8'd254);
`endif

    if (PULSE) count_d = tick_val;

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          // Drain the held tick first. A coincident tick takes the freed slot.
          wdata_d   = hold_q;
          state_d   = StWrite;
          pending_d = PULSE;
          if (PULSE) hold_d = tick_val;
        end else if (PULSE) begin
          wdata_d = tick_val;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (PULSE) begin
          if (pending_q) begin
            overrun_d = 1'b1;
          end else begin
            pending_d = 1'b1;
            hold_d    = tick_val;
          end
        end
        if (ACK) begin
          state_d = StIdle;
          addr_d  = addr_q + ADDR_W'(1);
          if (&addr_q) wrapped_d = 1'b1;
        end
`ifdef TICK_LOGGER_TIMEOUT_EN
        else if (timeout) begin
          // Abandon the write. ADDR keeps its value, so the slot is reused.
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      wrapped_q <= wrapped_d;
    end
  end

`ifdef TICK_LOGGER_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      timer_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign REQ     = (state_q == StWrite);
  assign ADDR    = addr_q;
  assign WDATA   = wdata_q;
  assign COUNT   = count_q;
  assign OVERRUN = overrun_q;
  assign WRAPPED = wrapped_q;

endmodule

// File: doc/tick_logger.md
TICK_LOGGER -- requirements
Module: tick_logger

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, count and write-data width.
REQ-003 SHALL have port CLK  input  1  system clock (100 MHz); all logic on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port PULSE  input  1  one-cycle tick from the 1 kHz pulse generator.
REQ-006 SHALL have port ACK  input  1  SRAM controller write acknowledge, one cycle.
REQ-007 SHALL have port REQ  output  1  write request to SRAM controller.
REQ-008 SHALL have port ADDR  output  ADDR_W  write address.
REQ-009 SHALL have port WDATA  output  DATA_W  write data.
REQ-010 SHALL have port COUNT  output  DATA_W  running tick count.
REQ-011 SHALL have port OVERRUN  output  1  sticky; a tick was dropped.
REQ-012 SHALL have port WRAPPED  output  1  sticky; ADDR has wrapped past its maximum.
REQ-013 SHALL have port ERR  output  1  sticky; ACK timeout (see Configuration).

Function
REQ-014 SHALL increment COUNT by 1, modulo 2^DATA_W, in the cycle after every PULSE=1, regardless of FSM state.
REQ-015 SHALL implement a two-state FSM: IDLE and WRITE.
REQ-016 IDLE with PULSE=1 SHALL register WDATA=COUNT+1 and enter WRITE, with REQ=1 from the next cycle.
REQ-017 IDLE with a pending entry SHALL register WDATA=hold value, clear pending, and enter WRITE next cycle.
REQ-018 If PULSE and pending coincide in IDLE, the pending entry SHALL be written first, the new tick SHALL become pending, and OVERRUN SHALL not change.
REQ-019 In WRITE, REQ SHALL stay 1, and ADDR and WDATA SHALL stay stable, until ACK=1.
REQ-020 WRITE with ACK=1 SHALL set REQ=0 next cycle, increment ADDR modulo 2^ADDR_W, and return to IDLE.
REQ-021 An ADDR increment from all-ones to 0 SHALL set WRAPPED.
REQ-022 PULSE in WRITE with pending=0 SHALL set pending and hold COUNT+1 in a one-entry hold register.
REQ-023 PULSE in WRITE with pending=1 SHALL set OVERRUN; the held value SHALL be unchanged; COUNT SHALL still increment.
REQ-024 Simultaneous ACK and PULSE in WRITE SHALL complete the write and capture the tick per REQ-022/REQ-023.
REQ-025 ACK received in IDLE SHALL be ignored.
REQ-026 Write latency SHALL be 1 cycle from PULSE to REQ=1 when the FSM is IDLE with no pending entry.

Reset
REQ-027 RST=1 SHALL set FSM=IDLE, REQ=0, ADDR=0, WDATA=0, COUNT=0, pending=0, hold=0, OVERRUN=0, WRAPPED=0, ERR=0, and timeout counter=0.
REQ-028 RST asserted mid-WRITE SHALL drop REQ the next cycle and discard the in-flight write and any pending entry.
REQ-029 RST SHALL take priority over PULSE and ACK in the same cycle.

Configuration
REQ-030 SHALL use macro TICK_LOGGER_TIMEOUT_EN to control the ACK timeout.
REQ-031 With the macro defined, an 8-bit counter SHALL count cycles in WRITE; if 255 cycles elapse without ACK, the block SHALL set ERR, drop REQ, and return to IDLE with ADDR unchanged and that write discarded.
REQ-032 Without the macro, WRITE SHALL wait indefinitely for ACK, ERR SHALL be constant 0, and no timeout counter SHALL be synthesized.

Verification
REQ-033 Reset, then PULSE at cycle 5, ACK at cycle 8 -> REQ=1 in cycles 6-8, ADDR=0, WDATA=1, then REQ=0 and ADDR=1 at cycle 9, COUNT=1.
REQ-034 PULSE during WRITE, then ACK -> second write starts 1 cycle after return to IDLE with WDATA=2, ADDR=1, OVERRUN=0.
REQ-035 Three PULSEs during one WRITE with ACK withheld -> OVERRUN=1, COUNT=4, next write WDATA=2.
REQ-036 ADDR_W=2, five serviced ticks -> ADDR sequence 0,1,2,3,0, WRAPPED=1 after the fourth ACK, fifth write at ADDR=0 with WDATA=5.
REQ-037 TICK_LOGGER_TIMEOUT_EN defined, ACK tied 0 -> REQ falls after 255 cycles, ERR=1, ADDR=0; without the macro -> REQ stays 1 for 1000 or more cycles and ERR=0.
REQ-038 RST pulsed for 1 cycle mid-WRITE with pending set -> REQ=0, COUNT=0, pending cleared, and no write follows.
